tx_rs232: RTL and testbench

UART RS232 transmitter. It is the upstream partner of the receiver stage and drives the serial line that the receiver samples. It serialises bytes into 11-bit frames: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1). Bit timing is set by a clock-per-bit count that matches the receiver's, so loopback works directly. A one-entry holding register lets the next byte be accepted mid-frame, giving back-to-back frames with no idle gap.

---
 rtl/tx_rs232.sv | 129 ++++++++++++
 tb/tb_tx_rs232.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_rs232.sv
// RS232 transmitter: 11-bit frames (start, 8 data LSB first, parity, stop)
// with a one-entry holding register for gapless back-to-back frames.
module tx_rs232 #(
  parameter int CLK_PER_BIT = 12,
  parameter int PARITY_ODD  = 0
) (
  input  logic       clk_s,
  input  logic       rst_s,
  input  logic [7:0] iDATA,
  input  logic       iVALID,
  output logic       oREADY,
  output logic       oTX,
  output logic       oBUSY,
  output logic       oDONE
);
  localparam int            CW       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic          PAR_INV  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shf_q, shf_d;
  logic [7:0]    hold_q, hold_d;
  logic          full_q, full_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          bit_end, accept, stop_end;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign accept   = iVALID && !full_q;
  assign stop_end = (state_q == STOP) && bit_end;

  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shf_d   = shf_q;
    hold_d  = hold_q;
    full_d  = full_q;
    par_d   = par_q;

    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (accept) begin
          shf_d   = iDATA;
          par_d   = (^iDATA) ^ PAR_INV;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        shf_d = {1'b0, shf_q[7:1]};
        if (bit_q == 3'd7) state_d = PARITY;
        else               bit_d   = bit_q + 3'd1;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        // A held byte (or one arriving right now) starts the next frame with no idle bit.
        if (full_q) begin
          shf_d   = hold_q;
          par_d   = (^hold_q) ^ PAR_INV;
          hold_d  = '0;
          full_d  = 1'b0;
          state_d = START;
        end else if (accept) begin
          shf_d   = iDATA;
          par_d   = (^iDATA) ^ PAR_INV;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept && (state_q != IDLE) && !stop_end) begin
      hold_d = iDATA;
      full_d = 1'b1;
    end
  end

  // Line level is registered from the next-state view so it lines up with the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shf_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign oTX    = tx_q;
  assign oBUSY  = (state_q != IDLE);
  assign oDONE  = stop_end;
  assign oREADY = !full_q;
endmodule

// File: tb/tb_tx_rs232.sv
// Directed bench for tx_rs232: exact frame timing, parity, back-to-back,
// stop-edge handoff, mid-frame reset and a bench-side serial receiver.
module tb_tx_rs232;
  localparam int CPB = 12;

  logic       clk_s, rst_s;
  logic [7:0] data, data_o;
  logic       valid, ready, tx, busy, done;
  logic       valid_o, ready_o, tx_o, busy_o, done_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit mon_en = 0;
  logic [10:0] mon_q[$];
  int          mon_t[$];

  tx_rs232 #(.CLK_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk_s(clk_s), .rst_s(rst_s), .iDATA(data), .iVALID(valid),
    .oREADY(ready), .oTX(tx), .oBUSY(busy), .oDONE(done));

  tx_rs232 #(.CLK_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
    .clk_s(clk_s), .rst_s(rst_s), .iDATA(data_o), .iVALID(valid_o),
    .oREADY(ready_o), .oTX(tx_o), .oBUSY(busy_o), .oDONE(done_o));

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  always @(posedge clk_s) cyc <= cyc + 1;
  always @(negedge clk_s) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serial receiver model: finds the start bit, samples each bit mid-cell.
  always begin : mon
    logic [10:0] fb;
    int t0;
    @(negedge clk_s);
    if (mon_en && tx === 1'b0) begin
      t0 = cyc;
      repeat (CPB / 2) @(negedge clk_s);
      fb[0] = tx;
      for (int k = 1; k < 11; k++) begin
        repeat (CPB) @(negedge clk_s);
        fb[k] = tx;
      end
      mon_q.push_back(fb);
      mon_t.push_back(t0);
    end
  end

  function automatic logic [10:0] frame(input logic [7:0] b, input logic p);
    return {1'b1, p, b, 1'b0};
  endfunction

  // One byte from idle, checked cycle by cycle against the expected frame.
  task automatic send_check(input bit odd, input logic [7:0] b, input logic p, input string tag);
    logic [10:0] fr;
    fr = frame(b, p);
    @(negedge clk_s);
    if (odd) begin data_o = b; valid_o = 1'b1; end
    else     begin data   = b; valid   = 1'b1; end
    @(negedge clk_s);
    valid = 1'b0; valid_o = 1'b0;
    for (int c = 0; c < 11 * CPB; c++) begin
      check({tag, "_tx"},   odd ? tx_o : tx,     fr[c / CPB]);
      check({tag, "_done"}, odd ? done_o : done, (c == 11 * CPB - 1));
      @(negedge clk_s);
    end
    check({tag, "_busy_end"}, odd ? busy_o : busy, 1'b0);
    check({tag, "_tx_end"},   odd ? tx_o : tx,     1'b1);
  endtask

  task automatic wait_idle(input string tag, output int end_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk_s);
      n++;
    end
    end_cyc = cyc;
    check({tag, "_idle_timeout"}, (n >= 2000), 1'b0);
  endtask

  initial begin : main
    logic [7:0] bytes[3];
    int k, n, d0, end_c, bad_tx, bad_busy;
    bit acc, found;
    rst_s = 1'b1; valid = 1'b0; data = '0; valid_o = 1'b0; data_o = '0;
    repeat (3) @(negedge clk_s);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", ready, 1'b1);
    rst_s = 1'b0;
    @(negedge clk_s);

    // Single frame, exact timing, then idle line.
    send_check(0, 8'hA5, 1'b0, "a5");
    repeat (5) begin
      @(negedge clk_s);
      check("a5_idle_tx", tx, 1'b1);
    end

    // Parity cases.
    send_check(1, 8'h00, 1'b1, "odd00");
    send_check(1, 8'hFF, 1'b1, "oddff");
    send_check(0, 8'h01, 1'b1, "ev01");
    send_check(0, 8'h03, 1'b0, "ev03");

    // Back-to-back with iVALID held high.
    mon_q.delete(); mon_t.delete(); mon_en = 1'b1;
    d0 = done_cnt;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    @(negedge clk_s);
    k = 0; data = bytes[0]; valid = 1'b1;
    n = 0;
    while (k < 3 && n < 1000) begin
      acc = valid && ready;
      @(negedge clk_s);
      n++;
      if (acc) begin
        k++;
        if (k == 1) check("b2b_ready_after1", ready, 1'b1);
        if (k == 2) check("b2b_ready_after2", ready, 1'b0);
        if (k < 3) data = bytes[k];
        else       valid = 1'b0;
      end
    end
    valid = 1'b0;
    check("b2b_accepts", k, 3);
    wait_idle("b2b", end_c);
    check("b2b_nframes", mon_q.size(), 3);
    if (mon_q.size() == 3) begin
      check("b2b_f0", mon_q[0], frame(8'h11, 1'b0));
      check("b2b_f1", mon_q[1], frame(8'h22, 1'b0));
      check("b2b_f2", mon_q[2], frame(8'h33, 1'b0));
      check("b2b_gap01", mon_t[1] - mon_t[0], 11 * CPB);
      check("b2b_gap12", mon_t[2] - mon_t[1], 11 * CPB);
      check("b2b_span", end_c - mon_t[0], 33 * CPB);
    end
    check("b2b_dones", done_cnt - d0, 3);

    // Handshake on the exact last STOP cycle with an empty holding register.
    repeat (3) @(negedge clk_s);
    mon_q.delete(); mon_t.delete();
    data = 8'h3C; valid = 1'b1;
    @(negedge clk_s);
    valid = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 300) begin
      @(negedge clk_s);
      n++;
      if (done === 1'b1) found = 1'b1;
    end
    check("edge_done_seen", found, 1'b1);
    data = 8'h96; valid = 1'b1;
    @(negedge clk_s);
    valid = 1'b0;
    check("edge_start_tx", tx, 1'b0);
    check("edge_start_busy", busy, 1'b1);
    check("edge_ready", ready, 1'b1);
    wait_idle("edge", end_c);
    check("edge_nframes", mon_q.size(), 2);
    if (mon_q.size() == 2) begin
      check("edge_f0", mon_q[0], frame(8'h3C, 1'b0));
      check("edge_f1", mon_q[1], frame(8'h96, 1'b0));
      check("edge_gap", mon_t[1] - mon_t[0], 11 * CPB);
    end
    mon_en = 1'b0;

    // Reset mid-DATA with a byte held.
    repeat (3) @(negedge clk_s);
    d0 = done_cnt;
    data = 8'h0F; valid = 1'b1;
    @(negedge clk_s);
    data = 8'h77;
    @(negedge clk_s);
    valid = 1'b0;
    check("rstmid_held", ready, 1'b0);
    repeat (40) @(negedge clk_s);
    check("rstmid_busy_before", busy, 1'b1);
    rst_s = 1'b1;
    @(negedge clk_s);
    rst_s = 1'b0;
    check("rstmid_tx", tx, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_done", done, 1'b0);
    check("rstmid_ready", ready, 1'b1);
    bad_tx = 0; bad_busy = 0;
    repeat (300) begin
      @(negedge clk_s);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("rstmid_line_quiet", bad_tx, 0);
    check("rstmid_stay_idle", bad_busy, 0);
    check("rstmid_no_done", done_cnt - d0, 0);

    // Loopback into the receiver model.
    mon_q.delete(); mon_t.delete(); mon_en = 1'b1;
    @(negedge clk_s);
    data = 8'h5A; valid = 1'b1;
    @(negedge clk_s);
    valid = 1'b0;
    repeat (20) @(negedge clk_s);
    data = 8'hC3; valid = 1'b1;
    @(negedge clk_s);
    valid = 1'b0;
    wait_idle("loop", end_c);
    check("loop_nframes", mon_q.size(), 2);
    if (mon_q.size() == 2) begin
      check("loop_5a", mon_q[0][8:1], 8'h5A);
      check("loop_c3", mon_q[1][8:1], 8'hC3);
      check("loop_f0", mon_q[0], frame(8'h5A, 1'b0));
      check("loop_f1", mon_q[1], frame(8'hC3, 1'b0));
    end
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
